dcache_port_arbiter: RTL
========================

// Module: dcache_port_arbiter
// PURPOSE
//  Shares the single dcache port (en/wren/addr/wdata/rdata/done) between two requesters:
//  req0 = Mem stage load/store, req1 = secondary client (page walker / fetch-miss fill).
//  Serialises accesses, latches the winning request, routes rdata/done back to its owner,
//  and detects a dcache that never asserts done. Sits between the Mem stage and the dcache.
// PARAMETERS
//  ADDR_W          64   address width
//  DATA_W          64   read/write data width
//  TIMEOUT_CYCLES  256  max WAIT cycles before abort; 0 disables the watchdog
// PORTS
//  clk          in   1       clock, all state updates on posedge
//  reset        in   1       synchronous, active-high reset
//  reqN_en      in   1       N=0,1: access request, level, held until reqN_done
//  reqN_wren    in   1       1 = write, 0 = read
//  reqN_addr    in   ADDR_W  access address
//  reqN_wdata   in   DATA_W  write data (ignored for reads)
//  reqN_rdata   out  DATA_W  read data, valid in the reqN_done cycle, held after it
//  reqN_done    out  1       one-cycle completion pulse to requester N
//  dcache_en    out  1       access strobe to dcache, held high until dcache_done
//  dcache_wren  out  1       write enable to dcache
//  dcache_addr  out  ADDR_W  address to dcache
//  dcache_wdata out  DATA_W  write data to dcache
//  dcache_rdata in   DATA_W  read data, valid with dcache_done
//  dcache_done  in   1       dcache completion pulse
//  timeout_err  out  1       one-cycle pulse when the watchdog aborts an access
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, owner 0, rr pointer 0, watchdog 0; dcache_done ignored.
//  - States: IDLE -> WAIT -> IDLE. Every output is registered.
//  - IDLE: eligible = reqN_en && !maskN. If any eligible: latch winner's wren/addr/wdata into
//    dcache_*, dcache_en<=1, owner<=winner, watchdog<=0, go WAIT. Else stay; outputs hold.
//  - WAIT: on dcache_done: dcache_en<=0, reqN_rdata<=dcache_rdata (reads only; writes leave
//    rdata unchanged), reqN_done<=1 for the owner only, go IDLE. Requester inputs ignored.
//  - Latency: request first sampled at edge t -> dcache_en high after t; dcache_done sampled at
//    edge k -> reqN_done high for the one cycle after k. Minimum request-to-done 2 cycles.
//  - Mask: maskN is set for the one cycle after reqN_done (req held high there is not
//    re-granted); in that cycle the other requester, if pending, wins.
//  - Watchdog (TIMEOUT_CYCLES>0): counts WAIT cycles; at count==TIMEOUT_CYCLES-1 without
//    dcache_done: dcache_en<=0, timeout_err<=1, no reqN_done, go IDLE, owner masked 1 cycle.
//    dcache_done and timeout in the same cycle: done wins, no error.
//  - dcache_done while IDLE (stray/late): ignored, no done pulse.
//  - reset mid-WAIT: access abandoned, no done pulse, dcache_en drops on that edge.
//  - wren/addr/wdata changes while WAIT: ignored; the latched copy is used.
// CONFIGURATION
//  DCACHE_ARB_RR_EN defined: round-robin; on a tie the requester not granted last wins
//    (rr pointer updates on every grant, reset grants req0 first).
//  Not defined: fixed priority, req0 always wins ties; req1 is served only when req0 is idle or masked.
// STRUCTURE
//  Shared header dcache_arb.svh: arb_state_t enum {ARB_IDLE, ARB_WAIT}, ARB_REQ0/ARB_REQ1 ids.
//  Sub-module dcache_arb_pick: combinational, (en0, en1, mask0, mask1, rr_ptr) -> grant_valid, grant_id.
//  Top holds the FSM, latches, watchdog and response routing.
// TESTING
//  1 req0 read addr 64'h1000, dcache_done 3 cycles after en, rdata 64'hCAFE -> dcache_addr=1000,
//    wren=0; req0_done one cycle, req0_rdata=CAFE; req1_done stays 0.
//  2 req1 write addr 64'h2000 wdata 64'h55 -> dcache_wren=1, wdata=55; req1_done pulse;
//    req1_rdata unchanged.
//  3 req0 and req1 assert same cycle, both held -> fixed: req0,req0-masked cycle gives req1;
//    RR_EN: grant order 0,1,0,1 over four accesses.
//  4 TIMEOUT_CYCLES=4, dcache_done never asserted -> dcache_en high exactly 4 cycles,
//    timeout_err one pulse, no reqN_done, next request accepted.
//  5 reset asserted in WAIT, dcache_done next cycle -> all outputs 0, no done pulse, state IDLE.
//  6 stray dcache_done in IDLE with no request -> no done, no error, outputs unchanged.

Source files
------------

// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types and helpers for the dcache port arbiter.
package dcache_port_arbiter_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_WAIT = 1'b1
   } arb_state_t;

   localparam logic ARB_REQ0 = 1'b0;
   localparam logic ARB_REQ1 = 1'b1;

   // Watchdog counter width; must hold TIMEOUT_CYCLES-1 and never be zero-width.
   function automatic int unsigned wdog_width(input int unsigned cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// One dcache-style access port: used for both requesters and the dcache side.
interface dcache_port_arbiter_if #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64
) ();

   logic              en;
   logic              wren;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              done;

   // master issues accesses, slave serves them.
   modport master (
      output en, wren, addr, wdata,
      input  rdata, done
   );

   modport slave (
      input  en, wren, addr, wdata,
      output rdata, done
   );

endinterface

// File: rtl/dcache_port_arbiter_pick.sv
// Combinational winner selection between the two requesters.
module dcache_port_arbiter_pick
   import dcache_port_arbiter_pkg::*;
(
   input  logic i_en0,
   input  logic i_en1,
   input  logic i_mask0,
   input  logic i_mask1,
   input  logic i_rr_ptr,
   output logic o_grant_valid,
   output logic o_grant_id
);

   logic w_elig0;
   logic w_elig1;

   always_comb begin
      w_elig0       = i_en0 && !i_mask0;
      w_elig1       = i_en1 && !i_mask1;
      o_grant_valid = w_elig0 || w_elig1;
      o_grant_id    = ARB_REQ0;
      // i_rr_ptr names the requester favoured on a tie.
      if (w_elig0 && w_elig1) begin
         o_grant_id = i_rr_ptr;
      end else if (w_elig1) begin
         o_grant_id = ARB_REQ1;
      end
   end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares one dcache port between two requesters with done routing and a watchdog.
// Define DCACHE_ARB_RR_EN for round-robin tie-breaking; default is fixed priority to req0.
module dcache_port_arbiter
   import dcache_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W         = 64,
   parameter int unsigned DATA_W         = 64,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   dcache_port_arbiter_if.slave  i_req0,
   dcache_port_arbiter_if.slave  i_req1,
   dcache_port_arbiter_if.master o_dcache,
   output logic                  o_timeout_err
);

   localparam int unsigned WDOG_W = wdog_width(TIMEOUT_CYCLES);

   arb_state_t        r_state,    w_state_nxt;
   logic              r_owner,    w_owner_nxt;
   logic [WDOG_W-1:0] r_wdog,     w_wdog_nxt;
   logic              r_mask0,    w_mask0_nxt;
   logic              r_mask1,    w_mask1_nxt;
   logic              r_dc_en,    w_dc_en_nxt;
   logic              r_dc_wren,  w_dc_wren_nxt;
   logic [ADDR_W-1:0] r_dc_addr,  w_dc_addr_nxt;
   logic [DATA_W-1:0] r_dc_wdata, w_dc_wdata_nxt;
   logic [DATA_W-1:0] r_rdata0,   w_rdata0_nxt;
   logic [DATA_W-1:0] r_rdata1,   w_rdata1_nxt;
   logic              r_done0,    w_done0_nxt;
   logic              r_done1,    w_done1_nxt;
   logic              r_terr,     w_terr_nxt;

   logic w_grant_valid;
   logic w_grant_id;
   logic w_rr_ptr;
   logic w_wdog_hit;

   dcache_port_arbiter_pick u_pick (
      .i_en0         (i_req0.en),
      .i_en1         (i_req1.en),
      .i_mask0       (r_mask0),
      .i_mask1       (r_mask1),
      .i_rr_ptr      (w_rr_ptr),
      .o_grant_valid (w_grant_valid),
      .o_grant_id    (w_grant_id)
   );

`ifdef DCACHE_ARB_RR_EN
   logic r_rr_ptr;

   // Point at the requester that lost the latest grant so it wins the next tie.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rr_ptr <= ARB_REQ0;
      end else if (r_state == ARB_IDLE && w_grant_valid) begin
         r_rr_ptr <= ~w_grant_id;
      end
   end

   assign w_rr_ptr = r_rr_ptr;
`else
   assign w_rr_ptr = ARB_REQ0;
`endif

   assign w_wdog_hit = (TIMEOUT_CYCLES != 0) &&
                       (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      w_state_nxt    = r_state;
      w_owner_nxt    = r_owner;
      w_wdog_nxt     = r_wdog;
      w_dc_en_nxt    = r_dc_en;
      w_dc_wren_nxt  = r_dc_wren;
      w_dc_addr_nxt  = r_dc_addr;
      w_dc_wdata_nxt = r_dc_wdata;
      w_rdata0_nxt   = r_rdata0;
      w_rdata1_nxt   = r_rdata1;
      w_done0_nxt    = 1'b0;
      w_done1_nxt    = 1'b0;
      w_mask0_nxt    = 1'b0;
      w_mask1_nxt    = 1'b0;
      w_terr_nxt     = 1'b0;

      case (r_state)
         ARB_IDLE: begin
            if (w_grant_valid) begin
               w_state_nxt = ARB_WAIT;
               w_owner_nxt = w_grant_id;
               w_wdog_nxt  = '0;
               w_dc_en_nxt = 1'b1;
               if (w_grant_id == ARB_REQ1) begin
                  w_dc_wren_nxt  = i_req1.wren;
                  w_dc_addr_nxt  = i_req1.addr;
                  w_dc_wdata_nxt = i_req1.wdata;
               end else begin
                  w_dc_wren_nxt  = i_req0.wren;
                  w_dc_addr_nxt  = i_req0.addr;
                  w_dc_wdata_nxt = i_req0.wdata;
               end
            end
         end

         ARB_WAIT: begin
            // Completion beats a watchdog expiry in the same cycle.
            if (o_dcache.done) begin
               w_state_nxt = ARB_IDLE;
               w_dc_en_nxt = 1'b0;
               if (r_owner == ARB_REQ1) begin
                  w_done1_nxt = 1'b1;
                  w_mask1_nxt = 1'b1;
                  if (!r_dc_wren) begin
                     w_rdata1_nxt = o_dcache.rdata;
                  end
               end else begin
                  w_done0_nxt = 1'b1;
                  w_mask0_nxt = 1'b1;
                  if (!r_dc_wren) begin
                     w_rdata0_nxt = o_dcache.rdata;
                  end
               end
            end else if (w_wdog_hit) begin
               w_state_nxt = ARB_IDLE;
               w_dc_en_nxt = 1'b0;
               w_terr_nxt  = 1'b1;
               if (r_owner == ARB_REQ1) begin
                  w_mask1_nxt = 1'b1;
               end else begin
                  w_mask0_nxt = 1'b1;
               end
            end else begin
               w_wdog_nxt = r_wdog + WDOG_W'(1);
            end
         end

         default: begin
            w_state_nxt = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ARB_IDLE;
         r_owner    <= ARB_REQ0;
         r_wdog     <= '0;
         r_mask0    <= 1'b0;
         r_mask1    <= 1'b0;
         r_dc_en    <= 1'b0;
         r_dc_wren  <= 1'b0;
         r_dc_addr  <= '0;
         r_dc_wdata <= '0;
         r_rdata0   <= '0;
         r_rdata1   <= '0;
         r_done0    <= 1'b0;
         r_done1    <= 1'b0;
         r_terr     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_owner    <= w_owner_nxt;
         r_wdog     <= w_wdog_nxt;
         r_mask0    <= w_mask0_nxt;
         r_mask1    <= w_mask1_nxt;
         r_dc_en    <= w_dc_en_nxt;
         r_dc_wren  <= w_dc_wren_nxt;
         r_dc_addr  <= w_dc_addr_nxt;
         r_dc_wdata <= w_dc_wdata_nxt;
         r_rdata0   <= w_rdata0_nxt;
         r_rdata1   <= w_rdata1_nxt;
         r_done0    <= w_done0_nxt;
         r_done1    <= w_done1_nxt;
         r_terr     <= w_terr_nxt;
      end
   end

   assign o_dcache.en    = r_dc_en;
   assign o_dcache.wren  = r_dc_wren;
   assign o_dcache.addr  = r_dc_addr;
   assign o_dcache.wdata = r_dc_wdata;
   assign i_req0.rdata   = r_rdata0;
   assign i_req0.done    = r_done0;
   assign i_req1.rdata   = r_rdata1;
   assign i_req1.done    = r_done1;
   assign o_timeout_err  = r_terr;

endmodule
